// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// MIPS funct codes and the controller state encoding.
package muldiv_pkg;

   localparam logic [5:0] FUNCT_MULT  = 6'b011000;
   localparam logic [5:0] FUNCT_MULTU = 6'b011001;
   localparam logic [5:0] FUNCT_DIV   = 6'b011010;
   localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
   localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
   localparam logic [5:0] FUNCT_MTLO  = 6'b010011;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX
   } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the {rem, acc} pair:
// shift-add for multiply, restore-subtract for divide.
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic             is_div,
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] acc,
   input  logic [WIDTH-1:0] opnd,
   output logic [WIDTH-1:0] rem_next,
   output logic [WIDTH-1:0] acc_next
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] diff;
   logic             ge;

   always_comb begin
      sum    = {1'b0, rem} + (acc[0] ? {1'b0, opnd} : '0);
      rem_sh = {rem, acc[WIDTH-1]};
      // rem < opnd holds, so a successful trial difference fits in WIDTH bits
      diff   = rem_sh[WIDTH-1:0] - opnd;
      ge     = rem_sh >= {1'b0, opnd};
      if (is_div) begin
         rem_next = ge ? diff : rem_sh[WIDTH-1:0];
         acc_next = {acc[WIDTH-2:0], ge};
      end else begin
         rem_next = sum[WIDTH:1];
         acc_next = {sum[0], acc[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative mult/div unit owning HI/LO; magnitudes are computed
// unsigned over WIDTH cycles and sign-corrected in a final FIX cycle.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   state_t           state;
   logic [CW-1:0]    cnt;
   logic             is_div;
   logic             neg_res;
   logic             neg_rem;
   logic             b_zero;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] opnd;
   logic [WIDTH-1:0] rem_nx;
   logic [WIDTH-1:0] acc_nx;

   logic               sgn;
   logic               is_md;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [2*WIDTH-1:0] prod;

   always_comb begin
      sgn   = ~funct[0];
      is_md = funct inside {FUNCT_MULT, FUNCT_MULTU,
                            FUNCT_DIV, FUNCT_DIVU};
      mag_a = (sgn && op_a[WIDTH-1]) ? -op_a : op_a;
      mag_b = (sgn && op_b[WIDTH-1]) ? -op_b : op_b;
      prod  = neg_res ? -{rem, acc} : {rem, acc};
   end

   assign busy = (state != IDLE);

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div   (is_div),
      .rem      (rem),
      .acc      (acc),
      .opnd     (opnd),
      .rem_next (rem_nx),
      .acc_next (acc_nx)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         cnt     <= '0;
         is_div  <= 1'b0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         b_zero  <= 1'b0;
         rem     <= '0;
         acc     <= '0;
         opnd    <= '0;
         hi      <= '0;
         lo      <= '0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (flush) begin
            state <= IDLE;
         end else begin
            unique case (state)
               IDLE: begin
                  if (start && is_md) begin
                     state   <= CALC;
                     cnt     <= '0;
                     is_div  <= funct[1];
                     neg_res <= sgn && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                     neg_rem <= sgn && op_a[WIDTH-1];
                     b_zero  <= (op_b == '0);
                     rem     <= '0;
                     acc     <= funct[1] ? mag_a : mag_b;
                     opnd    <= funct[1] ? mag_b : mag_a;
                  end else if (start && funct == FUNCT_MTHI) begin
                     hi <= op_a;
                  end else if (start && funct == FUNCT_MTLO) begin
                     lo <= op_a;
                  end
               end
               CALC: begin
                  rem <= rem_nx;
                  acc <= acc_nx;
                  cnt <= cnt + 1'b1;
                  if (cnt == CW'(WIDTH - 1)) state <= FIX;
               end
               FIX: begin
                  state <= IDLE;
                  done  <= 1'b1;
                  if (is_div) begin
                     lo <= b_zero ? '1 : (neg_res ? -acc : acc);
                     hi <= neg_rem ? -rem : rem;
                  end else begin
                     {hi, lo} <= prod;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed cases plus random
// traffic checked against a plain-arithmetic HI/LO model.
module tb_muldiv_unit;

   localparam int W = 32;

   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MTLO  = 6'b010011;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         start = 1'b0;
   logic         flush = 1'b0;
   logic [5:0]   funct = '0;
   logic [W-1:0] op_a = '0;
   logic [W-1:0] op_b = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int checks = 0;
   int failures = 0;

   logic [2*W-1:0] exp_q[$];
   logic [W-1:0]   m_hi = '0;
   logic [W-1:0]   m_lo = '0;

   always #5 clk = ~clk;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .funct   (funct),
      .op_a    (op_a),
      .op_b    (op_b),
      .flush   (flush),
      .busy    (busy),
      .done    (done),
      .hi      (hi),
      .lo      (lo)
   );

   task automatic chk(input string name, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [2*W-1:0] model(input logic [5:0] f,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
      longint sa, sb, q, r;
      logic [2*W-1:0] res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      res = {m_hi, m_lo};
      if (f == F_MULT) begin
         res = sa * sb;
      end else if (f == F_MULTU) begin
         res = {32'b0, a} * {32'b0, b};
      end else if (f == F_DIV || f == F_DIVU) begin
         if (b == 0) begin
            res = {a, {W{1'b1}}};
         end else if (f == F_DIV) begin
            q = sa / sb;
            r = sa % sb;
            res = {r[W-1:0], q[W-1:0]};
         end else begin
            res = {a % b, a / b};
         end
      end
      return res;
   endfunction

   always @(negedge clk) begin : monitor
      logic [2*W-1:0] e;
      if (reset_n && done) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done: hi=%h lo=%h, none expected",
                     hi, lo);
         end else begin
            e = exp_q.pop_front();
            chk("done_hi", hi, e[2*W-1:W]);
            chk("done_lo", lo, e[W-1:0]);
         end
      end
   end

   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 200) begin
         n++;
         @(negedge clk);
      end
   endtask

   // Called at a negedge; returns at the negedge where done is seen.
   task automatic run_op(input logic [5:0] f, input logic [W-1:0] a,
                         input logic [W-1:0] b);
      logic [2*W-1:0] e;
      int n;
      start = 1'b1;
      funct = f;
      op_a  = a;
      op_b  = b;
      e = model(f, a, b);
      exp_q.push_back(e);
      {m_hi, m_lo} = e;
      @(negedge clk);
      start = 1'b0;
      wait_idle(n);
      chk("busy_cycles", n, W + 1);
      chk("done_pulse", done, 1'b1);
   endtask

   task automatic mt(input logic [5:0] f, input logic [W-1:0] v);
      start = 1'b1;
      funct = f;
      op_a  = v;
      op_b  = $urandom;
      if (f == F_MTHI) m_hi = v;
      else m_lo = v;
      @(negedge clk);
      start = 1'b0;
      chk("mt_hi", hi, m_hi);
      chk("mt_lo", lo, m_lo);
      chk("mt_done", done, 1'b0);
      chk("mt_busy", busy, 1'b0);
   endtask

   function automatic logic [W-1:0] rnd_op();
      logic [W-1:0] v;
      case ($urandom_range(0, 7))
         0: v = '0;
         1: v = '1;
         2: v = 32'h8000_0000;
         3: v = W'($urandom_range(1, 20));
         4: v = -W'($urandom_range(1, 20));
         default: v = $urandom;
      endcase
      return v;
   endfunction

   initial begin
      logic [5:0] fsel [6];
      int n;
      fsel = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO};

      repeat (3) @(negedge clk);
      chk("rst_hi", hi, '0);
      chk("rst_busy", busy, 1'b0);
      reset_n = 1'b1;
      @(negedge clk);
      chk("idle_hi", hi, '0);
      chk("idle_lo", lo, '0);
      chk("idle_busy", busy, 1'b0);
      chk("idle_done", done, 1'b0);

      run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk("multu_max_hi", hi, 32'hFFFF_FFFE);
      chk("multu_max_lo", lo, 32'h0000_0001);
      run_op(F_MULT, -32'sd3, 32'd5);
      chk("mult_neg_hi", hi, 32'hFFFF_FFFF);
      chk("mult_neg_lo", lo, 32'hFFFF_FFF1);
      run_op(F_DIV, -32'sd7, 32'd2);
      chk("div_neg_lo", lo, 32'hFFFF_FFFD);
      chk("div_neg_hi", hi, 32'hFFFF_FFFF);
      run_op(F_DIVU, 32'd7, 32'd2);
      chk("divu_lo", lo, 32'd3);
      chk("divu_hi", hi, 32'd1);
      run_op(F_DIV, 32'd100, 32'd0);
      chk("div0_lo", lo, 32'hFFFF_FFFF);
      chk("div0_hi", hi, 32'h0000_0064);
      run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      chk("divovf_lo", lo, 32'h8000_0000);
      chk("divovf_hi", hi, 32'h0000_0000);

      mt(F_MTHI, 32'h1234);
      mt(F_MTLO, 32'h5678);
      chk("mt_lit_hi", hi, 32'h1234);
      chk("mt_lit_lo", lo, 32'h5678);

      // flush mid-multiply: HI/LO keep prior values, no done
      start = 1'b1;
      funct = F_MULT;
      op_a  = 32'd1000;
      op_b  = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_busy", busy, 1'b0);
      chk("flush_done", done, 1'b0);
      repeat (40) @(negedge clk);
      chk("flush_hi", hi, m_hi);
      chk("flush_lo", lo, m_lo);

      // flush together with start in IDLE
      start = 1'b1;
      funct = F_MULTU;
      flush = 1'b1;
      @(negedge clk);
      chk("flush_start_busy", busy, 1'b0);
      funct = F_MTHI;
      op_a  = 32'hBAD0_BAD0;
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      chk("flush_mthi_hi", hi, m_hi);

      // mthi while a divide is in flight is ignored
      start = 1'b1;
      funct = F_DIV;
      op_a  = 32'd1000;
      op_b  = 32'd7;
      exp_q.push_back(model(F_DIV, 32'd1000, 32'd7));
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      start = 1'b1;
      funct = F_MTHI;
      op_a  = 32'hDEAD;
      @(negedge clk);
      start = 1'b0;
      wait_idle(n);
      chk("busy_mthi_done", done, 1'b1);
      chk("busy_mthi_lo", lo, 32'd142);
      chk("busy_mthi_hi", hi, 32'd6);
      m_hi = 32'd6;
      m_lo = 32'd142;

      // asynchronous reset between edges mid-divide
      start = 1'b1;
      funct = F_DIVU;
      op_a  = 32'hFFFF_0000;
      op_b  = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_hi", hi, '0);
      chk("arst_lo", lo, '0);
      chk("arst_busy", busy, 1'b0);
      m_hi = '0;
      m_lo = '0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      run_op(F_MULTU, 32'd6, 32'd7);
      chk("post_rst_lo", lo, 32'd42);
      chk("post_rst_hi", hi, 32'd0);

      for (int i = 0; i < 40; i++) begin
         int k;
         k = $urandom_range(0, 5);
         if (k >= 4) mt(fsel[k], $urandom);
         else run_op(fsel[k], rnd_op(), rnd_op());
      end

      repeat (5) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: %0d results never seen",
                  exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
